// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline stage registers.
//   - pipe_state_e : occupancy encoding of a stage register (2'b11 is illegal)
//   - NOP_ISA      : ISA no-op word used to fill empty/flushed stages
//   - *_DATA_W     : packed payload widths per stage boundary
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } pipe_state_e;

  localparam logic [15:0] NOP_ISA = 16'h0800;

  // IF/ID: pc, instr
  localparam int unsigned FD_DATA_W = 16 + 16;
  // ID/EX: pc, rs1 value, rs2 value, imm, ctrl
  localparam int unsigned DX_DATA_W = 16 + 16 + 16 + 16 + 8;
  // EX/MEM: alu result, store data, rd, ctrl
  localparam int unsigned XM_DATA_W = 16 + 16 + 5 + 8;
  // MEM/WB: pc, result, wb_en, load data, mem_en, rd value, addr
  localparam int unsigned MW_DATA_W = 16 + 16 + 1 + 16 + 1 + 16 + 16;

  // True for the two encodings that hold a valid head entry.
  function automatic logic state_has_head(input pipe_state_e st);
    return (st == ST_ONE) || (st == ST_TWO);
  endfunction

endpackage

// File: rtl/dff.sv
// dff: plain W-bit D flip-flop cell without reset; any reset or clear
// behaviour is folded into the next-value mux in front of it.
//   clk : rising-edge clock
//   d   : next value
//   q   : registered value
module dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage element.
  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset (clears count)
//   inc   : add one this cycle unless saturated
//   clr   : synchronous clear, wins over inc
//   count : registered count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reset, then clear, then saturating increment.
  always_comb begin
    count_d = count_q;
    if (!rst) begin
      count_d = {W{1'b0}};
    end else if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with valid/ready handshake,
// synchronous flush, optional two-entry skid buffer and a stall counter.
//   clk       : rising-edge clock
//   rst       : synchronous active-low reset
//   flush     : squash all held entries (and the same-cycle accept)
//   in_valid  / in_ready  / in_data  : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and head payload
//   cnt_clr   : synchronous clear of stall_cnt
//   stall_cnt : saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter logic [255:0] NOP_VALUE = 256'(NOP_ISA),
  parameter bit          SKID_EN   = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [DATA_W-1:0] NOP_D = NOP_VALUE[DATA_W-1:0];

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] head_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              accept_s;
  logic              drain_s;

  assign out_valid = state_has_head(state_q);
  assign out_data  = head_q;

  // With the skid buffer in_ready is a pure decode of registered state, so
  // out_ready never reaches upstream combinationally; without it the single
  // entry can only be refilled in the cycle it drains.
  generate
    if (SKID_EN) begin : g_rdy_skid
      assign in_ready = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    end else begin : g_rdy_single
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept_s = in_valid && in_ready;
  assign drain_s  = out_valid && out_ready;

  // Occupancy and entry next-value mux: reset, then flush, then handshake.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (!rst || flush) begin
      state_d = ST_EMPTY;
      head_d  = NOP_D;
      skid_d  = NOP_D;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            head_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            head_d = in_data;
          end else if (accept_s) begin
            // Only reachable with the skid buffer: park the new entry.
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (drain_s) begin
            state_d = ST_EMPTY;
            head_d  = NOP_D;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (drain_s) begin
            state_d = ST_ONE;
            head_d  = skid_q;
            skid_d  = NOP_D;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          // Illegal encoding: drop everything and restart empty.
          state_d = ST_EMPTY;
          head_d  = NOP_D;
          skid_d  = NOP_D;
        end
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  dff #(.W(DATA_W)) u_head (.clk(clk), .d(head_d), .q(head_q));
  dff #(.W(DATA_W)) u_skid (.clk(clk), .d(skid_d), .q(skid_q));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .clr  (cnt_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst, flush, cnt_clr;
  // Shared stimulus for the skid instance and the 4-bit-counter instance.
  logic        in_valid, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, s_in_ready, s_out_valid;
  logic [15:0] out_data, s_out_data, stall_cnt;
  logic [3:0]  s_stall_cnt;
  // Single-entry instance.
  logic        n_in_valid, n_out_ready, n_in_ready, n_out_valid;
  logic [15:0] n_in_data, n_out_data, n_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .SKID_EN(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.DATA_W(16), .SKID_EN(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .cnt_clr(cnt_clr), .stall_cnt(s_stall_cnt));

  pipe_stage_reg #(.DATA_W(16), .SKID_EN(1'b0), .CNT_W(16)) u_ns (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .cnt_clr(cnt_clr), .stall_cnt(n_stall_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int got_n;
    int sent_n;
    int cyc;

    rst = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = 16'h0000; n_out_ready = 1'b0;

    // Reset held two cycles while upstream offers data.
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0800);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_ns_out_valid", 32'(n_out_valid), 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_empty_valid", 32'(out_valid), 32'd0);
    check("stream_empty_data", 32'(out_data), 32'h0800);
    check("stream_stall_cnt", 32'(stall_cnt), 32'd0);

    // Backpressure into the skid entry.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA001;
    tick();
    in_data = 16'hA002;
    #1;
    check("bp_ready_one", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'hA003;
    #1;
    check("bp_ready_two", 32'(in_ready), 32'd0);
    check("bp_head_hold", 32'(out_data), 32'hA001);
    tick(); tick();
    check("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    check("bp_head_hold2", 32'(out_data), 32'hA001);
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_path", 32'(in_ready), 32'd0);
    tick();
    check("bp_drain_a002", 32'(out_data), 32'hA002);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("bp_drain_a003", 32'(out_data), 32'hA003);
    check("bp_stall_kept", 32'(stall_cnt), 32'd3);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush while TWO, with a competing accept.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hB001;
    tick();
    in_data = 16'hB002;
    tick();
    flush = 1'b1; in_data = 16'hB003;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_data", 32'(out_data), 32'h0800);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_stall_cnt", 32'(stall_cnt), 32'd5);
    tick();
    check("flush_no_b003", 32'(out_valid), 32'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_stall_cnt", 32'(stall_cnt), 32'd0);

    // Saturation of a 4-bit counter with clear winning over increment.
    in_valid = 1'b1; in_data = 16'hC001;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("sat_cnt4", 32'(s_stall_cnt), 32'hF);
    check("sat_cnt16", 32'(stall_cnt), 32'd20);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("sat_clr4", 32'(s_stall_cnt), 32'd0);
    check("sat_clr16", 32'(stall_cnt), 32'd0);
    tick();
    check("sat_reinc", 32'(s_stall_cnt), 32'd1);

    // Reset in the middle of a transfer (skid holding two entries).
    in_valid = 1'b1; in_data = 16'hC002;
    tick();
    in_valid = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h0800);
    check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    check("mid_rst_stays_empty", 32'(out_valid), 32'd0);

    // Single-entry mode: in_ready follows out_ready combinationally when full.
    n_in_valid = 1'b1; n_in_data = 16'hD000;
    tick();
    n_in_valid = 1'b0;
    n_out_ready = 1'b0;
    #1;
    check("ns_ready_lo", 32'(n_in_ready), 32'd0);
    n_out_ready = 1'b1;
    #1;
    check("ns_ready_hi", 32'(n_in_ready), 32'd1);
    check("ns_head", 32'(n_out_data), 32'hD000);
    tick();
    check("ns_drained", 32'(n_out_valid), 32'd0);

    // Single-entry mode: 16 transfers with random downstream stalls.
    got_n = 0; sent_n = 0; cyc = 0;
    while (got_n < 16 && cyc < 400) begin
      n_in_valid  = (sent_n < 16);
      n_in_data   = 16'hE000 + 16'(sent_n);
      n_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (n_out_valid && n_out_ready) begin
        check("ns_order", 32'(n_out_data), 32'(16'hE000 + 16'(got_n)));
        got_n++;
      end
      if (n_in_valid && n_in_ready) sent_n++;
      tick();
      cyc++;
    end
    check("ns_all_received", 32'(got_n), 32'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register with an elastic interface that replaces the fixed field-by-field inter-stage latches.
- Carries one packed payload of DATA_W bits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds per-entry valid, ready/valid backpressure (stall), synchronous flush (bubble insert), an optional 2-entry skid buffer, and a saturating stall-cycle counter.
- The top level instantiates one per stage boundary and packs stage fields into in_data.

Parameters:
DATA_W, 16, payload width in bits (1..256)
NOP_VALUE, 16'h0800, value driven on out_data while empty or flushed; zero-extended or truncated to DATA_W
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low; state clears on a rising edge with rst==0
flush  input  1  synchronous active-high squash of all held entries
in_valid  input  1  upstream has a payload
in_ready  output  1  stage can accept this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data holds a valid payload
out_ready  input  1  downstream consumes this cycle
out_data  output  DATA_W  head payload
cnt_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Definitions: accept = in_valid && in_ready; drain = out_valid && out_ready.
- Priority per edge: rst==0 > flush > normal operation.
- Reset values:
  - state EMPTY, out_valid 0, out_data NOP_VALUE, skid register NOP_VALUE.
  - in_ready 1 when SKID_EN=1; when SKID_EN=0, in_ready follows its combinational rule.
  - stall_cnt 0.
- States (SKID_EN=1): EMPTY (no entries), ONE (head valid), TWO (head and skid valid).
  - in_ready = (state != TWO). It is a decode of registered state and has no path from out_ready.
  - EMPTY: accept -> ONE, head <= in_data.
  - ONE, accept && drain -> ONE, head <= in_data.
  - ONE, accept && !drain -> TWO, skid <= in_data.
  - ONE, !accept && drain -> EMPTY, head <= NOP_VALUE.
  - ONE, neither -> hold.
  - TWO, drain -> ONE, head <= skid, skid <= NOP_VALUE.
  - TWO, no drain -> hold (no accept possible).
- SKID_EN=0:
  - States EMPTY/ONE only.
  - in_ready = !out_valid || out_ready (combinational).
  - Transitions as above with the TWO arc removed.
- Output rules:
  - out_valid = (state != EMPTY).
  - out_data = head register, which equals NOP_VALUE whenever out_valid==0.
- Ordering: strictly FIFO. No payload is dropped or duplicated except by flush or reset.
- Hold: while out_valid && !out_ready, out_data is stable.
- flush==1: next state EMPTY, head and skid <= NOP_VALUE. The same-cycle accept is discarded, and a same-cycle drain still counts as consumed downstream.
  - out_valid is 0 on the cycle after flush.
  - in_ready is 1 on the cycle after flush.
- Latency: in_data accepted at edge N appears on out_data after edge N when the stage was empty, i.e. one cycle.
- Throughput: 1 payload/cycle sustained when out_ready is held high.
- stall_cnt:
  - Increments by 1 per cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority over increment.
  - Unaffected by flush; cleared by reset.
- Reset asserted mid-transfer discards all entries; no partial state survives.

Decomposition:
- Package pipe_pkg holds:
  - state encoding constants: EMPTY=2'b00, ONE=2'b01, TWO=2'b10; 2'b11 is illegal and recovers to EMPTY.
  - ISA NOP constant, 16'h0800.
  - Per-boundary payload width constants, e.g. MW_DATA_W = 16+16+1+16+1+16+16 = 82.
- One sub-module: sat_counter (parameter W; inputs clk, rst, inc, clr; output count), used for stall_cnt.
- Entry storage uses the existing dff cell arrayed DATA_W wide, with a next-value mux in front.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1, in_data=16'h1234 -> out_valid=0, out_data=16'h0800, stall_cnt=0; in_ready=1 after release.
- Streaming: SKID_EN=1, out_ready=1, send 16'h0001..16'h0008 on consecutive cycles -> same sequence on out_data one cycle later, no gaps, in_ready constantly 1.
- Backpressure:
  - SKID_EN=1, send 16'hA001, 16'hA002, 16'hA003 with out_ready=0 -> in_ready drops after the second accept, 16'hA003 is held upstream, and stall_cnt counts each stalled cycle.
  - Then release out_ready -> out_data shows A001, A002, A003 in order.
- Flush: state TWO holding 16'hB001, 16'hB002; flush=1 with in_valid=1, in_data=16'hB003 -> next cycle out_valid=0, out_data=16'h0800, B003 not captured, in_ready=1.
- Single-entry mode: SKID_EN=0, out_valid=1, out_ready toggled 0/1 -> in_ready == out_ready in the same cycle; no loss across 16 random-stall transfers compared against a scoreboard.
- Counter saturation: CNT_W=4, 20 stalled cycles -> stall_cnt sticks at 4'hF; cnt_clr=1 -> 0 next cycle.
